// File: rtl/trolley_system_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser + qualification FSM -> clean key_level, press/release pulses.
// Latency: key_level/pulse change DEBOUNCE_CYCLES+2 edges after the raw change is first sampled; no backpressure.
module trolley_system_key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_raw,
    output logic       key_level,
    output logic       key_press,
    output logic       key_release,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic                 IDLE_RAW = KEY_ACTIVE_LOW;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 press_q, press_d;
    logic                 release_q, release_d;
    logic [7:0]           bounce_q, bounce_d;
    logic                 s;
    logic [7:0]           bounce_inc;

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign bounce_cnt  = bounce_q;

    always_comb begin
        sync1_d    = key_raw;
        sync2_d    = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        bounce_d   = bounce_q;
        s          = sync2_q ^ IDLE_RAW;
        // Saturate at 255 so long-running diagnostics never wrap back to small values
        bounce_inc = (bounce_q == 8'hFF) ? bounce_q : bounce_q + 8'd1;

        case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d  = RELEASED;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    bounce_d = bounce_inc;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= IDLE_RAW;
            sync2_q   <= IDLE_RAW;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            bounce_q  <= 8'd0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            bounce_q  <= bounce_d;
        end
    end

endmodule
